// File: rtl/ps2_key_event.sv
// ============================================================================
//  Module   : ps2_key_event
//  Purpose  : PS/2 set-2 byte parser with held-key tracking, shift/caps
//             handling, ASCII translation and a key-event FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_key_event #(
   parameter int DEPTH     = 8,
   parameter int MAX_HELD  = 4,
   parameter int CNT_W     = 8,
   parameter int REPEAT_EN = 1
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ack,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic             ev_make,
   output logic             ev_ext,
   output logic             ev_rpt,
   output logic [7:0]       ev_code,
   output logic [6:0]       ev_ascii,
   output logic             shift,
   output logic             caps,
   output logic [CNT_W-1:0] press_cnt,
   output logic             overflow,
   input  logic             clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int EW = 18;
   localparam logic [7:0] c_e0 = 8'hE0;
   localparam logic [7:0] c_f0 = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t              r_state, w_nxt;
   logic                r_ack;
   logic                r_lshift, r_rshift, r_caps, r_ovf;
   logic [CNT_W-1:0]    r_cnt;
   logic [MAX_HELD-1:0] r_vld;
   logic [8:0]          r_key [MAX_HELD];
   logic [EW-1:0]       r_mem [DEPTH];
   logic [PW-1:0]       r_wr_ptr, r_rd_ptr;

   logic                w_accept, w_fire, w_make, w_ext;
   logic                w_hit, w_found, w_new_make, w_rpt, w_push;
   logic [MAX_HELD-1:0] w_hit_vec, w_ins_vec;
   logic                w_full, w_empty, w_pop, w_wr, w_drop;
   logic [6:0]          w_ascii;
   logic [EW-1:0]       w_wdata, w_head;

   function automatic logic [6:0] f_ascii(input logic [7:0] code, input logic upper);
      logic [6:0] v_up;
      logic [6:0] v_res;
      v_up  = 7'h00;
      v_res = 7'h00;
      case (code)
         8'h1C: v_up = 7'h41;  8'h32: v_up = 7'h42;  8'h21: v_up = 7'h43;
         8'h23: v_up = 7'h44;  8'h24: v_up = 7'h45;  8'h2B: v_up = 7'h46;
         8'h34: v_up = 7'h47;  8'h33: v_up = 7'h48;  8'h43: v_up = 7'h49;
         8'h3B: v_up = 7'h4A;  8'h42: v_up = 7'h4B;  8'h4B: v_up = 7'h4C;
         8'h3A: v_up = 7'h4D;  8'h31: v_up = 7'h4E;  8'h44: v_up = 7'h4F;
         8'h4D: v_up = 7'h50;  8'h15: v_up = 7'h51;  8'h2D: v_up = 7'h52;
         8'h1B: v_up = 7'h53;  8'h2C: v_up = 7'h54;  8'h3C: v_up = 7'h55;
         8'h2A: v_up = 7'h56;  8'h1D: v_up = 7'h57;  8'h22: v_up = 7'h58;
         8'h35: v_up = 7'h59;  8'h1A: v_up = 7'h5A;
         8'h45: v_res = 7'h30; 8'h16: v_res = 7'h31; 8'h1E: v_res = 7'h32;
         8'h26: v_res = 7'h33; 8'h25: v_res = 7'h34; 8'h2E: v_res = 7'h35;
         8'h36: v_res = 7'h36; 8'h3D: v_res = 7'h37; 8'h3E: v_res = 7'h38;
         8'h46: v_res = 7'h39;
         8'h29: v_res = 7'h20;
         8'h5A: v_res = 7'h0D;
         default: v_res = 7'h00;
      endcase
      if (v_up != 7'h00)
         v_res = upper ? v_up : (v_up + 7'h20);
      return v_res;
   endfunction

   // Prefix bytes only move the parser; a plain byte closes the sequence.
   always_comb begin
      w_accept = in_valid & ~r_ack;
      w_nxt    = r_state;
      w_fire   = 1'b0;
      w_make   = 1'b0;
      w_ext    = 1'b0;
      if (w_accept) begin
         if (in_data == c_e0)
            w_nxt = (r_state == S_BRK || r_state == S_EXT_BRK) ? S_EXT_BRK : S_EXT;
         else if (in_data == c_f0)
            w_nxt = (r_state == S_EXT || r_state == S_EXT_BRK) ? S_EXT_BRK : S_BRK;
         else if (in_data == 8'h00 || in_data == 8'hFF)
            w_nxt = S_IDLE;
         else begin
            w_nxt  = S_IDLE;
            w_fire = 1'b1;
            w_make = (r_state == S_IDLE) || (r_state == S_EXT);
            w_ext  = (r_state == S_EXT)  || (r_state == S_EXT_BRK);
         end
      end
   end

   always_comb begin
      w_hit_vec = '0;
      w_ins_vec = '0;
      w_found   = 1'b0;
      for (int i = 0; i < MAX_HELD; i++) begin
         w_hit_vec[i] = r_vld[i] && (r_key[i] == {w_ext, in_data});
         if (!r_vld[i] && !w_found) begin
            w_ins_vec[i] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

   assign w_hit      = |w_hit_vec;
   assign w_new_make = w_fire & w_make & ~w_hit;
   assign w_rpt      = w_fire & w_make & w_hit;
   assign w_push     = w_fire & (~w_rpt | (REPEAT_EN != 0));
   assign w_ascii    = w_ext ? 7'h00 : f_ascii(in_data, (r_lshift | r_rshift) ^ r_caps);
   assign w_wdata    = {w_make, w_ext, w_rpt, in_data, w_ascii};

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop   = ev_ready & ~w_empty;
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         r_state  <= S_IDLE;
         r_ack    <= 1'b0;
         r_lshift <= 1'b0;
         r_rshift <= 1'b0;
         r_caps   <= 1'b0;
         r_ovf    <= 1'b0;
         r_cnt    <= '0;
         r_vld    <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < MAX_HELD; i++)
            r_key[i] <= '0;
      end else begin
         r_state <= w_nxt;
         r_ack   <= w_accept;
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_drop)
            r_ovf <= 1'b1;
         else if (clr_ovf)
            r_ovf <= 1'b0;
         // A full table leaves the key untracked; it still counts as new.
         if (w_new_make) begin
            r_cnt <= r_cnt + CNT_W'(1);
            for (int i = 0; i < MAX_HELD; i++) begin
               if (w_ins_vec[i]) begin
                  r_vld[i] <= 1'b1;
                  r_key[i] <= {w_ext, in_data};
               end
            end
            if (!w_ext && in_data == 8'h58)
               r_caps <= ~r_caps;
         end
         if (w_fire && !w_make) begin
            for (int i = 0; i < MAX_HELD; i++)
               if (w_hit_vec[i])
                  r_vld[i] <= 1'b0;
         end
         if (w_fire && !w_ext && in_data == 8'h12)
            r_lshift <= w_make;
         if (w_fire && !w_ext && in_data == 8'h59)
            r_rshift <= w_make;
      end
   end

   assign w_head    = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
   assign ev_valid  = ~w_empty;
   assign ev_make   = w_head[17];
   assign ev_ext    = w_head[16];
   assign ev_rpt    = w_head[15];
   assign ev_code   = w_head[14:7];
   assign ev_ascii  = w_head[6:0];
   assign in_ack    = r_ack;
   assign shift     = r_lshift | r_rshift;
   assign caps      = r_caps;
   assign press_cnt = r_cnt;
   assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_event.sv
// ============================================================================
//  Module   : tb_ps2_key_event
//  Purpose  : Self-checking bench for ps2_key_event with an event scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_event;

   logic       clk = 1'b0;
   logic       rest = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ack;
   logic       ev_valid;
   logic       ev_ready = 1'b1;
   logic       ev_make, ev_ext, ev_rpt;
   logic [7:0] ev_code;
   logic [6:0] ev_ascii;
   logic       shift, caps, overflow;
   logic       clr_ovf = 1'b0;
   logic [7:0] press_cnt;

   logic       in1_valid = 1'b0;
   logic [7:0] in1_data = 8'h00;
   logic       in1_ack, ev1_valid, ev1_make, ev1_ext, ev1_rpt;
   logic [7:0] ev1_code;
   logic [6:0] ev1_ascii;
   logic       shift1, caps1, overflow1;
   logic [1:0] press_cnt1;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         ev1_seen = 0;
   logic [17:0] q [$];

   always #5 clk = ~clk;

   ps2_key_event #(.DEPTH(8), .MAX_HELD(4), .CNT_W(8), .REPEAT_EN(1)) dut (
      .clk(clk), .rest(rest), .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_make(ev_make), .ev_ext(ev_ext),
      .ev_rpt(ev_rpt), .ev_code(ev_code), .ev_ascii(ev_ascii), .shift(shift),
      .caps(caps), .press_cnt(press_cnt), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   ps2_key_event #(.DEPTH(4), .MAX_HELD(4), .CNT_W(2), .REPEAT_EN(0)) dut1 (
      .clk(clk), .rest(rest), .in_valid(in1_valid), .in_data(in1_data), .in_ack(in1_ack),
      .ev_valid(ev1_valid), .ev_ready(1'b1), .ev_make(ev1_make), .ev_ext(ev1_ext),
      .ev_rpt(ev1_rpt), .ev_code(ev1_code), .ev_ascii(ev1_ascii), .shift(shift1),
      .caps(caps1), .press_cnt(press_cnt1), .overflow(overflow1), .clr_ovf(1'b0)
   );

   // Scoreboard: every popped head is compared with the oldest expected event.
   always @(negedge clk) begin
      if (ev_valid && ev_ready) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_bad++;
            $display("FAIL event: unexpected actual=%h required=none",
                     {ev_make, ev_ext, ev_rpt, ev_code, ev_ascii});
         end else begin
            logic [17:0] exp_ev;
            exp_ev = q.pop_front();
            if ({ev_make, ev_ext, ev_rpt, ev_code, ev_ascii} !== exp_ev) begin
               n_bad++;
               $display("FAIL event: actual={mk%b ex%b rp%b %h %h} required={mk%b ex%b rp%b %h %h}",
                        ev_make, ev_ext, ev_rpt, ev_code, ev_ascii,
                        exp_ev[17], exp_ev[16], exp_ev[15], exp_ev[14:7], exp_ev[6:0]);
            end
         end
      end
   end

   always @(negedge clk) if (ev1_valid) ev1_seen++;

   task automatic expect_ev(input logic m, input logic e, input logic r,
                            input logic [7:0] code, input logic [6:0] asc);
      q.push_back({m, e, r, code, asc});
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic send1(input logic [7:0] b);
      in1_valid = 1'b1;
      in1_data  = b;
      @(posedge clk); #1;
      in1_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && (q.size() != 0 || ev_valid); i++) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rest = 1'b1; in_valid = 1'b0; in1_valid = 1'b0; clr_ovf = 1'b0; ev_ready = 1'b1;
      q.delete();
      repeat (2) @(posedge clk);
      #1 rest = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({ev_valid, in_ack, shift, caps, overflow} !== 5'b0) begin
         n_bad++; $display("FAIL reset_flags: actual=%b required=00000",
                           {ev_valid, in_ack, shift, caps, overflow});
      end
      n_cmp++;
      if (press_cnt !== 8'd0 || press_cnt1 !== 2'd0) begin
         n_bad++; $display("FAIL reset_cnt: actual=%0d/%0d required=0/0", press_cnt, press_cnt1);
      end
      n_cmp++;
      if ({ev_make, ev_ext, ev_rpt, ev_code, ev_ascii} !== 18'h0) begin
         n_bad++; $display("FAIL reset_head: actual=%h required=0",
                           {ev_make, ev_ext, ev_rpt, ev_code, ev_ascii});
      end
   endtask

   task automatic test_basic();
      do_reset();
      expect_ev(1, 0, 0, 8'h1C, 7'h61);
      in_valid = 1'b1; in_data = 8'h1C;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++;
      if ({in_ack, ev_valid} !== 2'b11) begin
         n_bad++; $display("FAIL ack_rise: actual ack/valid=%b required=11", {in_ack, ev_valid});
      end
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ack, ev_valid} !== 2'b00) begin
         n_bad++; $display("FAIL ack_fall: actual ack/valid=%b required=00", {in_ack, ev_valid});
      end
      expect_ev(0, 0, 0, 8'h1C, 7'h61);
      send_byte(8'hF0); send_byte(8'h1C);
      // in_valid held for three edges: second edge is blocked by in_ack.
      expect_ev(1, 0, 0, 8'h29, 7'h20);
      expect_ev(1, 0, 1, 8'h29, 7'h20);
      in_valid = 1'b1; in_data = 8'h29;
      repeat (3) @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk); #1;
      wait_drain();
      n_cmp++;
      if (q.size() != 0 || press_cnt !== 8'd2) begin
         n_bad++; $display("FAIL basic_end: actual pending=%0d cnt=%0d required=0/2", q.size(), press_cnt);
      end
   endtask

   task automatic test_shift_caps();
      do_reset();
      expect_ev(1, 0, 0, 8'h12, 7'h00); send_byte(8'h12);
      expect_ev(1, 0, 0, 8'h1C, 7'h41); send_byte(8'h1C);
      expect_ev(0, 0, 0, 8'h1C, 7'h41); send_byte(8'hF0); send_byte(8'h1C);
      expect_ev(0, 0, 0, 8'h12, 7'h00); send_byte(8'hF0); send_byte(8'h12);
      expect_ev(1, 0, 0, 8'h58, 7'h00); send_byte(8'h58);
      n_cmp++;
      if ({shift, caps} !== 2'b01) begin
         n_bad++; $display("FAIL caps_on: actual shift/caps=%b required=01", {shift, caps});
      end
      expect_ev(1, 0, 0, 8'h1C, 7'h41); send_byte(8'h1C);
      expect_ev(0, 0, 0, 8'h1C, 7'h41); send_byte(8'hF0); send_byte(8'h1C);
      expect_ev(1, 0, 0, 8'h12, 7'h00); send_byte(8'h12);
      expect_ev(1, 0, 0, 8'h1C, 7'h61); send_byte(8'h1C);
      expect_ev(1, 0, 0, 8'h16, 7'h31); send_byte(8'h16);
      expect_ev(1, 0, 0, 8'h5A, 7'h0D); send_byte(8'h5A);
      wait_drain();
      n_cmp++;
      if ({shift, caps} !== 2'b11 || press_cnt !== 8'd8 || q.size() != 0) begin
         n_bad++; $display("FAIL shift_end: actual shift/caps=%b cnt=%0d required=11 cnt=8",
                           {shift, caps}, press_cnt);
      end
   endtask

   task automatic test_repeat();
      do_reset();
      expect_ev(1, 0, 0, 8'h1C, 7'h61);
      expect_ev(1, 0, 1, 8'h1C, 7'h61);
      expect_ev(1, 0, 1, 8'h1C, 7'h61);
      repeat (3) send_byte(8'h1C);
      wait_drain();
      n_cmp++;
      if (press_cnt !== 8'd1 || q.size() != 0) begin
         n_bad++; $display("FAIL repeat_cnt: actual=%0d required=1", press_cnt);
      end
      ev1_seen = 0;
      repeat (3) send1(8'h1C);
      n_cmp++;
      if (ev1_seen != 1 || press_cnt1 !== 2'd1) begin
         n_bad++; $display("FAIL norepeat: actual events=%0d cnt=%0d required=1/1", ev1_seen, press_cnt1);
      end
      repeat (3) begin
         send1(8'hF0); send1(8'h1C); send1(8'h1C);
      end
      n_cmp++;
      if (ev1_seen != 7 || press_cnt1 !== 2'd0) begin
         n_bad++; $display("FAIL cnt_wrap: actual events=%0d cnt=%0d required=7/0", ev1_seen, press_cnt1);
      end
   endtask

   task automatic test_ext();
      do_reset();
      expect_ev(1, 1, 0, 8'h75, 7'h00); send_byte(8'hE0); send_byte(8'h75);
      expect_ev(0, 1, 0, 8'h75, 7'h00); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      expect_ev(0, 1, 0, 8'h75, 7'h00);
      send_byte(8'hE0); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      expect_ev(0, 1, 0, 8'h1C, 7'h00); send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h1C);
      expect_ev(1, 0, 0, 8'h75, 7'h00); send_byte(8'hE0); send_byte(8'h00); send_byte(8'h75);
      expect_ev(1, 0, 0, 8'h29, 7'h20); send_byte(8'hFF); send_byte(8'h29);
      wait_drain();
      n_cmp++;
      if (press_cnt !== 8'd3 || q.size() != 0) begin
         n_bad++; $display("FAIL ext_cnt: actual=%0d pending=%0d required=3/0", press_cnt, q.size());
      end
   endtask

   task automatic test_overflow();
      logic [7:0] codes [9];
      codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
      do_reset();
      ev_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) expect_ev(1, 0, 0, codes[i], 7'h61 + 7'(i));
         send_byte(codes[i]);
      end
      n_cmp++;
      if ({ev_valid, overflow} !== 2'b11 || press_cnt !== 8'd9 || ev_code !== 8'h1C) begin
         n_bad++; $display("FAIL ovf_set: actual v/o=%b cnt=%0d head=%h required=11 cnt=9 head=1c",
                           {ev_valid, overflow}, press_cnt, ev_code);
      end
      clr_ovf = 1'b1;
      @(posedge clk); #1;
      clr_ovf = 1'b0;
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++; $display("FAIL ovf_clr: actual=%b required=0", overflow);
      end
      expect_ev(1, 0, 0, 8'h3B, 7'h6A);
      in_valid = 1'b1; in_data = 8'h3B; ev_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; ev_ready = 1'b0;
      n_cmp++;
      if ({ev_valid, overflow} !== 2'b10) begin
         n_bad++; $display("FAIL push_pop_full: actual v/o=%b required=10", {ev_valid, overflow});
      end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 8'h42; clr_ovf = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; clr_ovf = 1'b0;
      n_cmp++;
      if (overflow !== 1'b1) begin
         n_bad++; $display("FAIL drop_beats_clr: actual=%b required=1", overflow);
      end
      @(posedge clk); #1;
      ev_ready = 1'b1;
      wait_drain();
      n_cmp++;
      if (q.size() != 0 || ev_valid || press_cnt !== 8'd11) begin
         n_bad++; $display("FAIL ovf_drain: actual pending=%0d valid=%b cnt=%0d required=0/0/11",
                           q.size(), ev_valid, press_cnt);
      end
   endtask

   task automatic test_held_full();
      logic [7:0] codes [5];
      codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         expect_ev(1, 0, 0, codes[i], 7'h61 + 7'(i));
         send_byte(codes[i]);
      end
      expect_ev(1, 0, 0, 8'h24, 7'h65); send_byte(8'h24);
      wait_drain();
      n_cmp++;
      if (press_cnt !== 8'd6 || q.size() != 0) begin
         n_bad++; $display("FAIL untracked: actual cnt=%0d required=6", press_cnt);
      end
      send_byte(8'hE0);
      rest = 1'b1;
      #2;
      n_cmp++;
      if ({ev_valid, in_ack, shift, caps, overflow} !== 5'b0 || press_cnt !== 8'd0) begin
         n_bad++; $display("FAIL async_rst: actual flags=%b cnt=%0d required=0/0",
                           {ev_valid, in_ack, shift, caps, overflow}, press_cnt);
      end
      @(posedge clk); #1;
      rest = 1'b0;
      @(posedge clk); #1;
      expect_ev(1, 0, 0, 8'h75, 7'h00); send_byte(8'h75);
      expect_ev(0, 0, 0, 8'h1C, 7'h61); send_byte(8'hF0); send_byte(8'h1C);
      wait_drain();
      n_cmp++;
      if (press_cnt !== 8'd1 || q.size() != 0) begin
         n_bad++; $display("FAIL post_rst: actual cnt=%0d pending=%0d required=1/0", press_cnt, q.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_shift_caps();
      test_repeat();
      test_ext();
      test_overflow();
      test_held_full();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
